// File: rtl/full_adder_pkg.sv
// Shared constants and the arithmetic reference for the ripple-carry adder.
// ref_add returns {carry, sum} in bits [width:0], computed with plain addition.
package full_adder_pkg;

  localparam int MAX_WIDTH = 64;

  function automatic logic [MAX_WIDTH:0] ref_add(
    input logic [MAX_WIDTH-1:0] a,
    input logic [MAX_WIDTH-1:0] b,
    input logic                 ci,
    input int unsigned          width
  );
    logic [MAX_WIDTH-1:0] mask;
    logic [MAX_WIDTH:0]   total;
    mask  = (width >= MAX_WIDTH) ? {MAX_WIDTH{1'b1}}
                                 : (({{(MAX_WIDTH-1){1'b0}}, 1'b1} << width) - 1'b1);
    total = {1'b0, a & mask} + {1'b0, b & mask} + {{MAX_WIDTH{1'b0}}, ci};
    return total;
  endfunction

endpackage

// File: rtl/full_adder_cell.sv
// 1-bit full adder: purely combinational, zero latency, no flow control.
module full_adder_cell
  import full_adder_pkg::*;
(
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);

  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (a & ci) | (b & ci);

endmodule

// File: rtl/full_adder_unit.sv
// WIDTH-bit ripple-carry adder; s/co are combinational, s_q/co_q/ovf_q/out_valid
// are captured one cycle after an in_valid strobe. Accepts one operand set per cycle, never stalls.
module full_adder_unit
  import full_adder_pkg::*;
#(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             ci,
  input  logic             in_valid,
  output logic [WIDTH-1:0] s,
  output logic             co,
  output logic [WIDTH-1:0] s_q,
  output logic             co_q,
  output logic             ovf_q,
  output logic             out_valid
);

  if (WIDTH < 1 || WIDTH > MAX_WIDTH) begin : g_bad_width
    $error("full_adder_unit: WIDTH out of range 1..64");
  end

  logic [WIDTH:0] c;
  logic           ovf;

  assign c[0] = ci;

  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    full_adder_cell u_cell (
      .a  (a[i]),
      .b  (b[i]),
      .ci (c[i]),
      .s  (s[i]),
      .co (c[i+1])
    );
  end

  assign co  = c[WIDTH];
  // Signed overflow: carry into the sign bit disagrees with carry out of it.
  assign ovf = c[WIDTH-1] ^ c[WIDTH];

  logic [WIDTH-1:0] sum_d, sum_q;
  logic             co_d, co_q_r;
  logic             ovf_d, ovf_q_r;
  logic             vld_d, vld_q;

  always_comb begin
    sum_d = sum_q;
    co_d  = co_q_r;
    ovf_d = ovf_q_r;
    vld_d = 1'b0;
    if (in_valid) begin
      sum_d = s;
      co_d  = co;
      ovf_d = ovf;
      vld_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sum_q   <= '0;
      co_q_r  <= 1'b0;
      ovf_q_r <= 1'b0;
      vld_q   <= 1'b0;
    end else begin
      sum_q   <= sum_d;
      co_q_r  <= co_d;
      ovf_q_r <= ovf_d;
      vld_q   <= vld_d;
    end
  end

  assign s_q       = sum_q;
  assign co_q      = co_q_r;
  assign ovf_q     = ovf_q_r;
  assign out_valid = vld_q;

endmodule

// File: tb/tb_full_adder_unit.sv
// Bench for full_adder_unit at WIDTH = 1, 8 and 32: directed cases plus random vectors
// scored against the package arithmetic reference and a sign-rule overflow model.
module tb_full_adder_unit;
  import full_adder_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n, in_valid;

  logic        a1, b1, ci1, s1, co1, sq1, coq1, ovfq1, ov1;
  logic [7:0]  a8, b8, s8, sq8;
  logic        ci8, co8, coq8, ovfq8, ov8;
  logic [31:0] a32, b32, s32, sq32;
  logic        ci32, co32, coq32, ovfq32, ov32;

  int checks = 0;
  int errors = 0;

  full_adder_unit #(.WIDTH(1)) u_w1 (
    .clk(clk), .rst_n(rst_n), .a(a1), .b(b1), .ci(ci1), .in_valid(in_valid),
    .s(s1), .co(co1), .s_q(sq1), .co_q(coq1), .ovf_q(ovfq1), .out_valid(ov1)
  );

  full_adder_unit #(.WIDTH(8)) u_w8 (
    .clk(clk), .rst_n(rst_n), .a(a8), .b(b8), .ci(ci8), .in_valid(in_valid),
    .s(s8), .co(co8), .s_q(sq8), .co_q(coq8), .ovf_q(ovfq8), .out_valid(ov8)
  );

  full_adder_unit #(.WIDTH(32)) u_w32 (
    .clk(clk), .rst_n(rst_n), .a(a32), .b(b32), .ci(ci32), .in_valid(in_valid),
    .s(s32), .co(co32), .s_q(sq32), .co_q(coq32), .ovf_q(ovfq32), .out_valid(ov32)
  );

  // Two's-complement overflow: operands share a sign and the result sign differs.
  function automatic logic sign_ovf(input logic [63:0] a, input logic [63:0] b,
                                    input logic [63:0] s, input int w);
    return (a[w-1] == b[w-1]) && (s[w-1] != a[w-1]);
  endfunction

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0;
    a1 = 0; b1 = 0; ci1 = 0; a8 = 0; b8 = 0; ci8 = 0; a32 = 0; b32 = 0; ci32 = 0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({sq8, coq8, ovfq8, ov8} !== 11'd0) begin
      errors++; $display("FAIL reset_w8_regs: got %h expected 000", {sq8, coq8, ovfq8, ov8});
    end
    checks++;
    if ({sq1, coq1, ovfq1, ov1} !== 4'd0) begin
      errors++; $display("FAIL reset_w1_regs: got %h expected 0", {sq1, coq1, ovfq1, ov1});
    end
    checks++;
    if ({sq32, coq32, ovfq32, ov32} !== 35'd0) begin
      errors++; $display("FAIL reset_w32_regs: got %h expected 0", {sq32, coq32, ovfq32, ov32});
    end
    checks++;
    if ({s8, co8} !== 9'd0) begin
      errors++; $display("FAIL zero_w8_comb: got %h expected 000", {s8, co8});
    end
    checks++;
    if ({s32, co32} !== 33'd0) begin
      errors++; $display("FAIL zero_w32_comb: got %h expected 0", {s32, co32});
    end
    rst_n = 1'b1;
  endtask

  task automatic test_w1_comb();
    logic [4:0] tbl [7];
    logic [4:0] e;
    // {a, b, ci, expected s, expected co}
    tbl = '{5'b000_00, 5'b010_10, 5'b110_01, 5'b001_10, 5'b011_01, 5'b111_11, 5'b110_01};
    for (int i = 0; i < 7; i++) begin
      e = tbl[i];
      a1 = e[4]; b1 = e[3]; ci1 = e[2];
      #5;
      checks++;
      if ({s1, co1} !== e[1:0]) begin
        errors++;
        $display("FAIL w1_comb[%0d]: got s,co=%b%b expected %b", i, s1, co1, e[1:0]);
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic test_w8_wrap();
    a8 = 8'hFF; b8 = 8'h01; ci8 = 1'b0;
    #5;
    checks++;
    if ({co8, s8} !== 9'h100) begin
      errors++; $display("FAIL w8_wrap: got co,s=%h expected 100", {co8, s8});
    end
    a8 = 8'hFF; b8 = 8'hFF; ci8 = 1'b1; a32 = '1; b32 = '1; ci32 = 1'b1;
    #1;
    checks++;
    if ({co8, s8} !== 9'h1FF) begin
      errors++; $display("FAIL w8_all_ones: got co,s=%h expected 1ff", {co8, s8});
    end
    checks++;
    if ({co32, s32} !== 33'h1_FFFF_FFFF) begin
      errors++; $display("FAIL w32_all_ones: got co,s=%h expected 1ffffffff", {co32, s32});
    end
    @(posedge clk); #1;
    a8 = 8'h7F; b8 = 8'h01; ci8 = 1'b0; in_valid = 1'b1;
    #2;
    checks++;
    if ({co8, s8} !== 9'h080) begin
      errors++; $display("FAIL w8_7f_comb: got co,s=%h expected 080", {co8, s8});
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    checks++;
    if ({sq8, coq8, ovfq8, ov8} !== {8'h80, 1'b0, 1'b1, 1'b1}) begin
      errors++;
      $display("FAIL w8_7f_reg: got s_q=%h co_q=%b ovf_q=%b vld=%b expected 80 0 1 1",
               sq8, coq8, ovfq8, ov8);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] ta [3], tb [3], es [3];
    logic       tc [3], eco [3];
    ta = '{8'h10, 8'hF0, 8'h00}; tb = '{8'h20, 8'h20, 8'h00}; tc = '{1'b0, 1'b1, 1'b0};
    es = '{8'h30, 8'h11, 8'h00}; eco = '{1'b0, 1'b1, 1'b0};
    for (int i = 0; i < 3; i++) begin
      a8 = ta[i]; b8 = tb[i]; ci8 = tc[i]; in_valid = 1'b1;
      @(posedge clk); #1;
      checks++;
      if ({sq8, coq8, ovfq8, ov8} !== {es[i], eco[i], 1'b0, 1'b1}) begin
        errors++;
        $display("FAIL b2b[%0d]: got s_q=%h co_q=%b ovf_q=%b vld=%b expected %h %b 0 1",
                 i, sq8, coq8, ovfq8, ov8, es[i], eco[i]);
      end
    end
    in_valid = 1'b0; a8 = 8'h55; b8 = 8'h11;
    @(posedge clk); #1;
    checks++;
    if ({sq8, coq8, ov8} !== {8'h00, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL b2b_drop: got s_q=%h co_q=%b vld=%b expected 00 0 0", sq8, coq8, ov8);
    end
  endtask

  task automatic test_reset_midstream();
    a8 = 8'h12; b8 = 8'h34; ci8 = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    rst_n = 1'b0; a8 = 8'hFF; b8 = 8'hFF;
    for (int i = 0; i < 2; i++) begin
      #1;
      checks++;
      if ({co8, s8} !== 9'h1FE) begin
        errors++; $display("FAIL rst_comb[%0d]: got co,s=%h expected 1fe", i, {co8, s8});
      end
      @(posedge clk); #1;
      checks++;
      if ({sq8, coq8, ovfq8, ov8} !== 11'd0) begin
        errors++;
        $display("FAIL rst_hold[%0d]: got %h expected 000", i, {sq8, coq8, ovfq8, ov8});
      end
    end
    rst_n = 1'b1; in_valid = 1'b0;
    @(posedge clk); #1;
    checks++;
    if ({sq8, ov8} !== 9'd0) begin
      errors++; $display("FAIL rst_release: got s_q,vld=%h expected 000", {sq8, ov8});
    end
  endtask

  task automatic test_random();
    logic [64:0] r1, r8, r32;
    logic [63:0] e_sq1, e_sq8, e_sq32;
    logic        e_co1, e_co8, e_co32, e_ov1, e_ov8, e_ov32, e_vld, v;
    e_sq1 = 0; e_sq8 = 0; e_sq32 = 0;
    e_co1 = 0; e_co8 = 0; e_co32 = 0; e_ov1 = 0; e_ov8 = 0; e_ov32 = 0;
    for (int n = 0; n < 1000; n++) begin
      a1 = 1'($urandom); b1 = 1'($urandom); ci1 = 1'($urandom);
      a8 = 8'($urandom); b8 = 8'($urandom); ci8 = 1'($urandom);
      a32 = $urandom; b32 = $urandom; ci32 = 1'($urandom);
      v = ($urandom_range(0, 3) != 0);
      in_valid = v;
      #1;
      r1  = ref_add({63'd0, a1}, {63'd0, b1}, ci1, 1);
      r8  = ref_add({56'd0, a8}, {56'd0, b8}, ci8, 8);
      r32 = ref_add({32'd0, a32}, {32'd0, b32}, ci32, 32);
      checks++;
      if ({co1, s1} !== r1[1:0]) begin
        errors++; $display("FAIL rand_w1_comb[%0d]: got %b expected %b", n, {co1, s1}, r1[1:0]);
      end
      checks++;
      if ({co8, s8} !== r8[8:0]) begin
        errors++; $display("FAIL rand_w8_comb[%0d]: got %h expected %h", n, {co8, s8}, r8[8:0]);
      end
      checks++;
      if ({co32, s32} !== r32[32:0]) begin
        errors++;
        $display("FAIL rand_w32_comb[%0d]: got %h expected %h", n, {co32, s32}, r32[32:0]);
      end
      if (v) begin
        e_sq1 = {63'd0, r1[0]};  e_co1 = r1[1];
        e_sq8 = {56'd0, r8[7:0]}; e_co8 = r8[8];
        e_sq32 = {32'd0, r32[31:0]}; e_co32 = r32[32];
        e_ov1 = sign_ovf({63'd0, a1}, {63'd0, b1}, e_sq1, 1);
        e_ov8 = sign_ovf({56'd0, a8}, {56'd0, b8}, e_sq8, 8);
        e_ov32 = sign_ovf({32'd0, a32}, {32'd0, b32}, e_sq32, 32);
      end
      e_vld = v;
      @(posedge clk); #1;
      checks++;
      if ({sq1, coq1, ovfq1, ov1} !== {e_sq1[0], e_co1, e_ov1, e_vld}) begin
        errors++;
        $display("FAIL rand_w1_reg[%0d]: got %b expected %b", n,
                 {sq1, coq1, ovfq1, ov1}, {e_sq1[0], e_co1, e_ov1, e_vld});
      end
      checks++;
      if ({sq8, coq8, ovfq8, ov8} !== {e_sq8[7:0], e_co8, e_ov8, e_vld}) begin
        errors++;
        $display("FAIL rand_w8_reg[%0d]: got %h expected %h", n,
                 {sq8, coq8, ovfq8, ov8}, {e_sq8[7:0], e_co8, e_ov8, e_vld});
      end
      checks++;
      if ({sq32, coq32, ovfq32, ov32} !== {e_sq32[31:0], e_co32, e_ov32, e_vld}) begin
        errors++;
        $display("FAIL rand_w32_reg[%0d]: got %h expected %h", n,
                 {sq32, coq32, ovfq32, ov32}, {e_sq32[31:0], e_co32, e_ov32, e_vld});
      end
    end
    in_valid = 1'b0;
  endtask

  initial begin
    test_reset();
    test_w1_comb();
    test_w8_wrap();
    test_back_to_back();
    test_reset_midstream();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/full_adder_unit.md
Name: full_adder_unit

Overview:
- Parameterizable ripple-carry adder built from 1-bit full-adder cells.
- Sum and carry-out are purely combinational from a, b, ci.
- An optional registered copy (s_q, co_q, ovf_q, out_valid) serves synchronous consumers.
- At WIDTH=1 it is the basic full adder used across the Basys3 sandbox datapaths.

Parameters:
- WIDTH, 1, operand/sum width in bits (legal range 1..64).

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  synchronous active-low reset.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- ci  input  1  carry-in.
- in_valid  input  1  capture strobe for the register stage.
- s  output  WIDTH  combinational sum, equal to (a + b + ci) mod 2^WIDTH.
- co  output  1  combinational carry-out of the MSB.
- s_q  output  WIDTH  registered sum.
- co_q  output  1  registered carry-out.
- ovf_q  output  1  registered signed overflow, equal to carry into MSB XOR carry out of MSB.
- out_valid  output  1  registered-result valid flag.

Behaviour:
- Clocking and reset: one clock domain (clk). Reset is synchronous and active-low (rst_n).
- Cell equations: s[i] = a[i] ^ b[i] ^ c[i]; c[i+1] = a[i]&b[i] | a[i]&c[i] | b[i]&c[i]; c[0] = ci; co = c[WIDTH].
- Combinational path:
  - s and co settle within the same delta time as an input change. There is no clock dependency and no reset effect.
  - Inputs X/Z propagate per standard operators. No masking is applied.
- Register stage, evaluated on each rising clk:
  - If rst_n = 0: s_q, co_q, ovf_q and out_valid all go to 0. Reset overrides in_valid.
  - Else if in_valid = 1: s_q <= s, co_q <= co, ovf_q <= overflow, out_valid <= 1.
  - Else: s_q, co_q and ovf_q hold; out_valid <= 0.
- Latency:
  - Combinational outputs: 0 cycles.
  - Registered outputs: 1 cycle after the in_valid sample.
- Back-to-back in_valid: one result per cycle; no stall and no backpressure.
- Boundary cases:
  - All-ones + all-ones + ci=1 gives s = all-ones, co = 1.
  - All-zeros with ci=0 gives s = 0, co = 0.
  - Wrap-around is modulo 2^WIDTH, with carry reported on co.
- Reset mid-stream: a result captured in the reset cycle is discarded; out_valid reads 0 the next cycle.
- The combinational ports must not be routed through the flops.

Decomposition:
- Shared package full_adder_pkg: localparam MAX_WIDTH = 64.
- Shared package full_adder_pkg: function for the reference sum/carry, reused by the bench scoreboard.
- One sub-module, full_adder_cell (a, b, ci -> s, co), instantiated WIDTH times via generate with the carry chained.

Test Plan:
- WIDTH=1, a=0 b=0 ci=0 -> s=0 co=0; a=0 b=1 ci=0 -> s=1 co=0; a=1 b=1 ci=0 -> s=0 co=1, each checked 5 ns after the change with no clock edge.
- WIDTH=1, a=0 b=0 ci=1 -> s=1 co=0; a=0 b=1 ci=1 -> s=0 co=1; a=1 b=1 ci=1 -> s=1 co=1; then ci=0 with a=1 b=1 -> s=0 co=1.
- WIDTH=8, a=0xFF b=0x01 ci=0 -> s=0x00 co=1; a=0x7F b=0x01 ci=0 with in_valid=1 -> next cycle s_q=0x80 co_q=0 ovf_q=1 out_valid=1.
- WIDTH=8, in_valid pulses on 3 consecutive cycles with (0x10,0x20,0), (0xF0,0x20,1), (0x00,0x00,0):
  - Registered results 0x30/0, 0x11/1, 0x00/0 on successive cycles.
  - out_valid drops the cycle after the last strobe while s_q holds 0x00.
- Hold rst_n=0 with in_valid=1 and a=b=0xFF for 2 cycles -> s_q=0 co_q=0 ovf_q=0 out_valid=0. Combinational s=0xFE co=1 throughout.
- Randomized 1000 vectors at WIDTH=1, 8 and 32 -> s, co and s_q/co_q match the package reference function.
